bus_initiator: RTL and testbench

- Bus master that drives the tc_ request/acknowledge bus of the transaction engine from a simple valid/ready command stream, and returns the outcome on a valid/ready response stream.
- Sits directly upstream of the engine's tc_ port. Its bus outputs connect to the same nets the protocol assertion checker monitors (req, readWrite_n, addressAck, writeAck, readAck).
- Issues one transaction at a time, with a data-phase timeout and a sticky protocol-error flag.

---
 rtl/bus_initiator.sv | 155 +++++++++++++++
 tb/tb_bus_initiator.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_initiator.sv
// Single-outstanding bus master: turns a valid/ready command stream into tc_ bus
// transactions and returns the outcome on a valid/ready response stream.
module bus_initiator #(
   parameter int AWIDTH         = 8,
   parameter int DWIDTH         = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              i_clk,
   input  logic              i_srst,
   input  logic              i_cmdValid,
   output logic              o_cmdReady,
   input  logic              i_cmdReadWrite_n,
   input  logic [AWIDTH-1:0] i_cmdAddr,
   input  logic [DWIDTH-1:0] i_cmdWdata,
   output logic              o_req,
   output logic              o_readWrite_n,
   output logic [AWIDTH-1:0] o_addr,
   output logic [DWIDTH-1:0] o_wdata,
   input  logic              i_addressAck,
   input  logic              i_writeAck,
   input  logic              i_readAck,
   input  logic [DWIDTH-1:0] i_rdata,
   output logic              o_rspValid,
   input  logic              i_rspReady,
   output logic              o_rspIsRead,
   output logic [DWIDTH-1:0] o_rspRdata,
   output logic              o_rspTimeout,
   output logic              o_protocolError
);

   // state | meaning
   // IDLE  | waiting for a command, o_cmdReady high
   // ADDR  | o_req high, waiting for i_addressAck
   // DATA  | waiting for the data ack, timer running
   // RESP  | response presented, waiting for i_rspReady
   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT_CYCLES);

   state_t            state_q, state_d;
   logic              rnw_q, rnw_d;
   logic [AWIDTH-1:0] addr_q, addr_d;
   logic [DWIDTH-1:0] wdata_q, wdata_d;
   logic [DWIDTH-1:0] rdata_q, rdata_d;
   logic              tout_q, tout_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic              timed_out_q, timed_out_d;
   logic              prot_err_q, prot_err_d;

   logic          exp_ack, wrong_ack, any_data_ack, in_xfer, bad;
   logic [TW-1:0] timer_inc;

   always_comb begin
      state_d      = state_q;
      rnw_d        = rnw_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      tout_d       = tout_q;
      timer_d      = timer_q;
      timed_out_d  = timed_out_q;
      prot_err_d   = prot_err_q;
      exp_ack      = rnw_q ? i_readAck  : i_writeAck;
      wrong_ack    = rnw_q ? i_writeAck : i_readAck;
      any_data_ack = i_writeAck | i_readAck;
      in_xfer      = (state_q == S_ADDR) || (state_q == S_DATA);
      timer_inc    = (timer_q == T_LIMIT) ? timer_q : timer_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            if (i_cmdValid) begin
               rnw_d   = i_cmdReadWrite_n;
               addr_d  = i_cmdAddr;
               wdata_d = i_cmdWdata;
               rdata_d = '0;
               tout_d  = 1'b0;
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            if (i_addressAck) begin
               timer_d     = '0;
               timed_out_d = 1'b0;
               if (exp_ack) begin
                  if (rnw_q) rdata_d = i_rdata;
                  state_d = S_RESP;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            timer_d = timer_inc;
            // ack beats the timeout when both land in the same cycle
            if (exp_ack) begin
               if (rnw_q) rdata_d = i_rdata;
               state_d = S_RESP;
            end else if (timer_inc == T_LIMIT) begin
               tout_d      = 1'b1;
               rdata_d     = '0;
               timed_out_d = 1'b1;
               state_d     = S_RESP;
            end
         end
         S_RESP: begin
            if (i_rspReady) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      bad = (i_addressAck && (state_q != S_ADDR))
         || (any_data_ack && !in_xfer)
         || (wrong_ack && in_xfer)
         || (i_writeAck && i_readAck)
         || (timed_out_q && any_data_ack && !i_addressAck);
      if (bad) prot_err_d = 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         state_q     <= S_IDLE;
         rnw_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         tout_q      <= 1'b0;
         timer_q     <= '0;
         timed_out_q <= 1'b0;
         prot_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rnw_q       <= rnw_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         tout_q      <= tout_d;
         timer_q     <= timer_d;
         timed_out_q <= timed_out_d;
         prot_err_q  <= prot_err_d;
      end
   end

   assign o_cmdReady      = (state_q == S_IDLE);
   assign o_req           = (state_q == S_ADDR);
   assign o_readWrite_n   = rnw_q;
   assign o_addr          = addr_q;
   assign o_wdata         = wdata_q;
   assign o_rspValid      = (state_q == S_RESP);
   assign o_rspIsRead     = rnw_q;
   assign o_rspRdata      = rdata_q;
   assign o_rspTimeout    = tout_q;
   assign o_protocolError = prot_err_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator: write, same-cycle read, timeout, backpressure,
// wrong-type ack and reset mid-transaction.
module tb_bus_initiator;
   logic       clk = 1'b0;
   logic       srst;
   logic       cmd_valid, cmd_ready, cmd_rnw;
   logic [7:0] cmd_addr, cmd_wdata;
   logic       req, rnw;
   logic [7:0] addr, wdata;
   logic       address_ack, write_ack, read_ack;
   logic [7:0] rdata;
   logic       rsp_valid, rsp_ready, rsp_is_read, rsp_timeout, prot_err;
   logic [7:0] rsp_rdata;

   int checks = 0;
   int errors = 0;
   int req_cnt;

   always #5 clk = ~clk;

   bus_initiator #(.AWIDTH(8), .DWIDTH(8), .TIMEOUT_CYCLES(16)) dut (
      .i_clk(clk), .i_srst(srst),
      .i_cmdValid(cmd_valid), .o_cmdReady(cmd_ready),
      .i_cmdReadWrite_n(cmd_rnw), .i_cmdAddr(cmd_addr), .i_cmdWdata(cmd_wdata),
      .o_req(req), .o_readWrite_n(rnw), .o_addr(addr), .o_wdata(wdata),
      .i_addressAck(address_ack), .i_writeAck(write_ack), .i_readAck(read_ack),
      .i_rdata(rdata),
      .o_rspValid(rsp_valid), .i_rspReady(rsp_ready), .o_rspIsRead(rsp_is_read),
      .o_rspRdata(rsp_rdata), .o_rspTimeout(rsp_timeout), .o_protocolError(prot_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      req_cnt += int'(req);
   endtask

   task automatic issue(input logic r, input logic [7:0] a, input logic [7:0] d);
      cmd_valid = 1'b1; cmd_rnw = r; cmd_addr = a; cmd_wdata = d;
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      srst = 1'b1; cmd_valid = 0; cmd_rnw = 0; cmd_addr = 0; cmd_wdata = 0;
      address_ack = 0; write_ack = 0; read_ack = 0; rdata = 0; rsp_ready = 0;
      req_cnt = 0;
      tick(); tick();
      srst = 1'b0;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_req", req, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_prot_err", prot_err, 0);
      chk("rst_addr", addr, 8'h00);
      chk("rst_rsp_rdata", rsp_rdata, 8'h00);

      // write, address ack 2 cycles after req rises, write ack 1 cycle later
      chk("wr_req_before", req, 0);
      req_cnt = 0;
      issue(1'b0, 8'h3C, 8'hA5);
      chk("wr_req_rise", req, 1);
      chk("wr_addr", addr, 8'h3C);
      chk("wr_wdata", wdata, 8'hA5);
      chk("wr_rnw", rnw, 0);
      chk("wr_cmd_ready", cmd_ready, 0);
      tick();
      tick();
      address_ack = 1'b1;
      chk("wr_req_at_aack", req, 1);
      tick();
      address_ack = 1'b0; write_ack = 1'b1;
      chk("wr_req_dropped", req, 0);
      chk("wr_addr_held", addr, 8'h3C);
      tick();
      write_ack = 1'b0;
      chk("wr_req_cycles", req_cnt, 3);
      chk("wr_rsp_valid", rsp_valid, 1);
      chk("wr_rsp_is_read", rsp_is_read, 0);
      chk("wr_rsp_timeout", rsp_timeout, 0);
      chk("wr_rsp_rdata", rsp_rdata, 8'h00);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("wr_back_idle", cmd_ready, 1);
      chk("wr_rsp_gone", rsp_valid, 0);
      chk("wr_prot_err", prot_err, 0);

      // read with address and read ack in the same cycle, then 5 cycles of backpressure
      issue(1'b1, 8'h81, 8'h00);
      chk("rd_req", req, 1);
      chk("rd_rnw", rnw, 1);
      chk("rd_addr", addr, 8'h81);
      address_ack = 1'b1; read_ack = 1'b1; rdata = 8'h5E;
      tick();
      address_ack = 1'b0; read_ack = 1'b0; rdata = 8'h00;
      chk("rd_rsp_valid", rsp_valid, 1);
      chk("rd_rsp_rdata", rsp_rdata, 8'h5E);
      chk("rd_rsp_is_read", rsp_is_read, 1);
      chk("rd_rsp_timeout", rsp_timeout, 0);
      cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_addr = 8'hEE; cmd_wdata = 8'h11;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_rsp_rdata", rsp_rdata, 8'h5E);
         chk("bp_rsp_is_read", rsp_is_read, 1);
         chk("bp_cmd_ready", cmd_ready, 0);
         chk("bp_no_req", req, 0);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("rd_back_idle", cmd_ready, 1);
      chk("rd_prot_err", prot_err, 0);

      // write timeout: no write ack ever arrives in DATA
      issue(1'b0, 8'h10, 8'h22);
      address_ack = 1'b1;
      tick();
      address_ack = 1'b0;
      chk("to_in_data", req, 0);
      for (int i = 1; i < 16; i++) begin
         tick();
         chk("to_not_yet", rsp_valid, 0);
      end
      tick();
      chk("to_rsp_valid", rsp_valid, 1);
      chk("to_rsp_timeout", rsp_timeout, 1);
      chk("to_rsp_rdata", rsp_rdata, 8'h00);
      chk("to_prot_err_clean", prot_err, 0);
      write_ack = 1'b1;
      tick();
      write_ack = 1'b0;
      chk("to_late_ack_err", prot_err, 1);
      chk("to_rsp_still", rsp_valid, 1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("to_err_sticky", prot_err, 1);

      srst = 1'b1;
      tick();
      srst = 1'b0;
      chk("rst2_prot_err", prot_err, 0);

      // write ack on the last DATA cycle beats the timeout
      issue(1'b0, 8'h20, 8'h33);
      address_ack = 1'b1;
      tick();
      address_ack = 1'b0;
      for (int i = 1; i < 16; i++) tick();
      chk("edge_not_yet", rsp_valid, 0);
      write_ack = 1'b1;
      tick();
      write_ack = 1'b0;
      chk("edge_rsp_valid", rsp_valid, 1);
      chk("edge_rsp_timeout", rsp_timeout, 0);
      chk("edge_prot_err", prot_err, 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // wrong-type ack during a read
      issue(1'b1, 8'h44, 8'h00);
      address_ack = 1'b1;
      tick();
      address_ack = 1'b0; write_ack = 1'b1;
      tick();
      write_ack = 1'b0;
      chk("wt_prot_err", prot_err, 1);
      chk("wt_no_rsp", rsp_valid, 0);
      chk("wt_no_req", req, 0);
      tick();
      chk("wt_still_data", rsp_valid, 0);
      read_ack = 1'b1; rdata = 8'hC3;
      tick();
      read_ack = 1'b0; rdata = 8'h00;
      chk("wt_rsp_valid", rsp_valid, 1);
      chk("wt_rsp_rdata", rsp_rdata, 8'hC3);
      chk("wt_rsp_is_read", rsp_is_read, 1);
      chk("wt_rsp_timeout", rsp_timeout, 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // reset while in ADDR abandons the transaction
      issue(1'b0, 8'h55, 8'h66);
      chk("mr_req", req, 1);
      srst = 1'b1;
      tick();
      srst = 1'b0;
      chk("mr_req_dropped", req, 0);
      chk("mr_cmd_ready", cmd_ready, 1);
      chk("mr_prot_err", prot_err, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mr_no_rsp", rsp_valid, 0);
         chk("mr_no_req", req, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
